game_irq_scheduler: RTL and testbench
=====================================

// Module: game_irq_scheduler
// PURPOSE
//  Interrupt scheduler for the KCPSM6 game controller. Generates a programmable
//  periodic game tick and button-change events, queues them as pending causes,
//  and runs the interrupt/interrupt_ack handshake with KCPSM6. Software reads the
//  cause register and writes end-of-interrupt through its own I/O ports.
//  Sits beside game_interface on the port_id/out_port bus. The top level ORs
//  irq_in_port into in_port when irq_rd_sel=1.
// PARAMETERS
//  PRESCALE     100000  clk cycles per 1 ms timebase pulse (100 MHz)
//  CFG_PORT     8'h0A   write: enable mask; [0]=tick [1]=btn [2]=overrun
//  PERIOD_PORT  8'h0B   write: tick period in ms, 8 bits; 0 = timer stopped
//  CAUSE_PORT   8'h0C   read: cause snapshot {5'b0,ovr,btn,tick}
//  EOI_PORT     8'h0D   write (any data): end of interrupt service
// PORTS
//  clk          in   1  system clock
//  reset_n      in   1  synchronous reset, active low
//  db_btns      in   4  debounced buttons
//  port_id      in   8  KCPSM6 port address
//  out_port     in   8  KCPSM6 write data
//  write_strobe in   1  KCPSM6 write qualifier
//  read_strobe  in   1  KCPSM6 read qualifier; unused, reads have no side effect
//  interrupt    out  1  to KCPSM6
//  interrupt_ack in  1  from KCPSM6
//  irq_in_port  out  8  registered read data for CAUSE_PORT, 0 otherwise
//  irq_rd_sel   out  1  registered: port_id == CAUSE_PORT
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): interrupt=0, irq_in_port=0, irq_rd_sel=0.
//   Mask=0, period=0, pending=0, cause=0, prescaler=0, ms counter=0.
//   Button history is loaded with the current db_btns. State goes to IDLE.
//   A reset in any state aborts service in that same edge.
//  Timebase: prescaler counts 0..PRESCALE-1. A 1-clk ms pulse fires on wrap.
//   ms counter increments on each pulse. When it reaches period-1 on a pulse, it
//   clears and raises tick_evt for 1 clk. With period=0, the counter is held at 0
//   and no tick_evt occurs.
//   A PERIOD_PORT write loads the new period and clears the ms counter. The
//   prescaler keeps running.
//  btn_evt = (db_btns != history). History updates every clk.
//  Pending flags (tick, btn, ovr) are set by an event only if its mask bit is 1.
//   ovr sets when tick_evt arrives while the tick flag is already pending.
//   Clearing a mask bit does not clear its pending flag.
//  FSM states:
//   IDLE -> ASSERT when any pending flag is 1. interrupt goes to 1 on that edge.
//    Latency: event at edge N, pending at N+1, interrupt=1 at N+2.
//   ASSERT: interrupt held at 1 until interrupt_ack=1. On the ack edge:
//    cause <= pending | events in this cycle; pending <= 0; interrupt <= 0;
//    state -> SERVICE.
//   SERVICE: new events accumulate in pending; interrupt stays 0.
//    An EOI_PORT write moves to IDLE. If anything is pending, or an event lands
//    in the EOI cycle, interrupt=1 again one cycle after the IDLE edge.
//   An EOI write in IDLE or ASSERT is ignored.
//  Read path: irq_rd_sel and irq_in_port are registered from port_id each clk,
//   meeting KCPSM6 2-cycle input timing. Cause holds its value until the next ack.
//  Widths: counters are unsigned with no saturation. The prescaler counter is
//   $clog2(PRESCALE) bits.
// STRUCTURE
//  Package game_io_pkg: port-address localparams (including 8'h00-8'h0F of
//   game_interface), cause bit indices CAUSE_TICK=0, CAUSE_BTN=1, CAUSE_OVR=2,
//   and the FSM state encoding IDLE=2'd0, ASSERT=2'd1, SERVICE=2'd2.
//  One sub-module, game_tick_timer: prescaler, ms counter, period register;
//   outputs tick_evt. The FSM, pending/cause logic and port decode stay top-level.
// TESTING (PRESCALE=4 in simulation)
//  1 Reset mid-ASSERT with interrupt=1: drop reset_n for 1 clk
//    -> interrupt=0, cause=0, no tick for the next 100 clks.
//  2 Mask=8'h01, period=3: tick_evt every 12 clks -> interrupt=1 two clks after
//    the event. Ack -> read CAUSE_PORT = 8'h01; EOI returns to IDLE.
//  3 Mask=8'h07, withhold ack across 2 tick periods -> cause=8'h05 at ack.
//  4 Mask=8'h02, toggle db_btns[2] in SERVICE -> interrupt stays 0.
//    EOI -> interrupt=1 one clk after IDLE; cause=8'h02 after the next ack.
//  5 btn_evt on the same clk as interrupt_ack -> included in cause (8'h02);
//    pending=0 afterwards.
//  6 Period write of 0 while running -> no further interrupts over 200 clks.
//    EOI written in IDLE -> no state change.

Source files
------------

// File: rtl/game_io_pkg.sv
// Shared definitions for the KCPSM6 game controller I/O map and the
// interrupt scheduler: port addresses, cause bit positions, FSM encoding.
package game_io_pkg;

  // Address window owned by game_interface / the game I/O block.
  localparam logic [7:0] GAME_PORT_FIRST = 8'h00;
  localparam logic [7:0] GAME_PORT_LAST  = 8'h0F;

  // Interrupt scheduler registers inside that window.
  localparam logic [7:0] CFG_PORT    = 8'h0A;
  localparam logic [7:0] PERIOD_PORT = 8'h0B;
  localparam logic [7:0] CAUSE_PORT  = 8'h0C;
  localparam logic [7:0] EOI_PORT    = 8'h0D;

  // Bit positions shared by the enable mask, pending flags and cause register.
  localparam int CAUSE_TICK = 0;
  localparam int CAUSE_BTN  = 1;
  localparam int CAUSE_OVR  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/game_irq_scheduler_if.sv
// KCPSM6 port bus and interrupt handshake seen by the interrupt scheduler.
// Handshake: interrupt is held high until a clk edge samples interrupt_ack=1
// while interrupt=1; that edge completes the transfer and drops interrupt.
// interrupt_ack while interrupt=0 has no effect.
interface game_irq_scheduler_if;
  import game_io_pkg::*;

  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] irq_in_port;
  logic       irq_rd_sel;
  irq_state_e fsm_state;     // debug view of the scheduler FSM

  modport master (
    output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    input  interrupt, irq_in_port, irq_rd_sel, fsm_state
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    output interrupt, irq_in_port, irq_rd_sel, fsm_state
  );
endinterface

// File: rtl/game_tick_timer.sv
// Programmable game tick: a PRESCALE-cycle prescaler makes a 1 ms pulse,
// and an ms counter turns every period pulses into a one-clk tick_evt.
module game_tick_timer #(
  parameter int PRESCALE = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       period_wr,
  input  logic [7:0] period_data,
  output logic       tick_evt
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q;
  logic [7:0]    ms_q;
  logic [7:0]    period_q;
  logic          ms_pulse;

  assign ms_pulse = (presc_q == PRESCALE_LAST);

  // Free-running prescaler; period writes do not disturb its phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else if (ms_pulse) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Period register and ms counter; a period write restarts the count and
  // a period of 0 parks the counter so no tick is produced.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ms_q     <= 8'd0;
      period_q <= 8'd0;
      tick_evt <= 1'b0;
    end else begin
      tick_evt <= 1'b0;
      if (period_wr) begin
        period_q <= period_data;
        ms_q     <= 8'd0;
      end else if (ms_pulse && (period_q != 8'd0)) begin
        if (ms_q == period_q - 8'd1) begin
          ms_q     <= 8'd0;
          tick_evt <= 1'b1;
        end else begin
          ms_q <= ms_q + 8'd1;
        end
      end
    end
  end
endmodule

// File: rtl/game_irq_scheduler.sv
// Interrupt scheduler for the KCPSM6 game controller: collects tick and
// button events into pending causes, raises interrupt, snapshots the cause
// on acknowledge and waits for software end-of-interrupt.
module game_irq_scheduler
  import game_io_pkg::*;
#(
  parameter int PRESCALE = 100000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           db_btns,
  game_irq_scheduler_if.slave  bus
);
  logic [2:0] mask_q;
  logic [2:0] pending_q;
  logic [2:0] cause_q;
  logic [2:0] ev;
  logic [3:0] hist_q;
  logic       tick_evt;
  logic       btn_evt;
  logic       cfg_wr;
  logic       period_wr;
  logic       eoi_wr;
  logic       ack_take;
  logic       rd_sel_q;
  logic [7:0] rd_data_q;
  logic       unused_read_strobe;
  irq_state_e state_q;
  irq_state_e state_d;

  // Reads have no side effect, so the read qualifier is not needed.
  assign unused_read_strobe = bus.read_strobe;

  assign cfg_wr    = bus.write_strobe && (bus.port_id == CFG_PORT);
  assign period_wr = bus.write_strobe && (bus.port_id == PERIOD_PORT);
  assign eoi_wr    = bus.write_strobe && (bus.port_id == EOI_PORT);
  assign btn_evt   = (db_btns != hist_q);
  assign ack_take  = (state_q == ASSERT) && bus.interrupt_ack;

  game_tick_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .period_wr   (period_wr),
    .period_data (bus.out_port),
    .tick_evt    (tick_evt)
  );

  // Events of this cycle, gated by the enable mask; overrun means a new
  // tick arrived while the previous tick was still pending.
  always_comb begin
    ev             = 3'b000;
    ev[CAUSE_TICK] = tick_evt && mask_q[CAUSE_TICK];
    ev[CAUSE_BTN]  = btn_evt && mask_q[CAUSE_BTN];
    ev[CAUSE_OVR]  = tick_evt && pending_q[CAUSE_TICK] && mask_q[CAUSE_OVR];
  end

  // Next-state logic of the interrupt handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending_q != 3'b000) state_d = ASSERT;
      ASSERT:  if (bus.interrupt_ack)   state_d = SERVICE;
      SERVICE: if (eoi_wr)              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Mask, button history, pending accumulation and cause snapshot on ack.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q    <= 3'b000;
      pending_q <= 3'b000;
      cause_q   <= 3'b000;
      hist_q    <= db_btns;
    end else begin
      hist_q <= db_btns;
      if (cfg_wr) mask_q <= bus.out_port[2:0];
      if (ack_take) begin
        cause_q   <= pending_q | ev;
        pending_q <= 3'b000;
      end else begin
        pending_q <= pending_q | ev;
      end
    end
  end

  // Registered read path for the two-cycle KCPSM6 input timing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_sel_q  <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      rd_sel_q  <= (bus.port_id == CAUSE_PORT);
      rd_data_q <= (bus.port_id == CAUSE_PORT) ? {5'b00000, cause_q} : 8'h00;
    end
  end

  assign bus.interrupt   = (state_q == ASSERT);
  assign bus.irq_in_port = rd_data_q;
  assign bus.irq_rd_sel  = rd_sel_q;
  assign bus.fsm_state   = state_q;
endmodule

// File: tb/tb_game_irq_scheduler.sv
// Bench for game_irq_scheduler with a 4-cycle prescaler.
module tb_game_irq_scheduler;
  import game_io_pkg::*;

  localparam int P = 4;

  typedef struct {
    logic [7:0] pid;
    logic [7:0] data;
    logic       wr;
    logic       ack;
    logic [3:0] btns;
    logic       exp_irq;
    logic       exp_sel;
    logic [7:0] exp_rd;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] db_btns;
  logic       chk_en;
  int         n_vec = 0;
  int         n_err = 0;
  vec_t       tbl[17];

  game_irq_scheduler_if bus();

  game_irq_scheduler #(.PRESCALE(P)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .db_btns (db_btns),
    .bus     (bus)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: event rules written directly in terms of elapsed
  // cycles, ms pulses since the last period write, and service status.
  bit [2:0]    m_mask, m_pend, m_cause;
  bit [3:0]    m_hist;
  bit          m_irq, m_svc, m_tick, m_sel;
  bit [7:0]    m_rd;
  int unsigned m_cyc, m_pulses, m_period;

  task automatic model_edge();
    bit [2:0] evs;
    bit [2:0] old;
    bit       wr_cfg, wr_per, wr_eoi;
    if (!reset_n) begin
      m_mask = 0; m_pend = 0; m_cause = 0; m_hist = db_btns;
      m_irq = 0; m_svc = 0; m_tick = 0; m_sel = 0; m_rd = 0;
      m_cyc = 0; m_pulses = 0; m_period = 0;
      return;
    end
    wr_cfg = bus.write_strobe && bus.port_id == CFG_PORT;
    wr_per = bus.write_strobe && bus.port_id == PERIOD_PORT;
    wr_eoi = bus.write_strobe && bus.port_id == EOI_PORT;
    evs[0] = m_tick && m_mask[0];
    evs[1] = (db_btns != m_hist) && m_mask[1];
    evs[2] = m_tick && m_pend[0] && m_mask[2];
    m_sel  = (bus.port_id == CAUSE_PORT);
    m_rd   = m_sel ? {5'b0, m_cause} : 8'h00;
    old    = m_pend;
    if (m_irq && bus.interrupt_ack) begin
      m_cause = old | evs; m_pend = 0; m_irq = 0; m_svc = 1;
    end else begin
      m_pend = old | evs;
      if (!m_irq && !m_svc && old != 0) m_irq = 1;
      else if (m_svc && wr_eoi)         m_svc = 0;
    end
    m_tick = 0;
    if (wr_per) begin
      m_period = bus.out_port; m_pulses = 0;
    end else if ((m_cyc % P) == P - 1 && m_period != 0) begin
      m_pulses++;
      if (m_pulses % m_period == 0) m_tick = 1;
    end
    m_cyc++;
    if (wr_cfg) m_mask = bus.out_port[2:0];
    m_hist = db_btns;
  endtask

  // scoreboard: every cycle the DUT outputs are compared against the model
  always @(posedge clk) begin
    model_edge();
    #1;
    if (chk_en) begin
      check("mdl_interrupt", bus.interrupt, m_irq);
      check("mdl_rd_sel", bus.irq_rd_sel, m_sel);
      check("mdl_in_port", bus.irq_in_port, m_rd);
      check("mdl_state", bus.fsm_state, m_svc ? 2 : (m_irq ? 1 : 0));
    end
  end

  // driver tasks: one bus cycle driven at negedge, returns 1 after posedge
  task automatic step(input logic [7:0] pid, input logic [7:0] data,
                      input logic wr, input logic ack, input logic [3:0] btns);
    @(negedge clk);
    bus.port_id       = pid;
    bus.out_port      = data;
    bus.write_strobe  = wr;
    bus.read_strobe   = (pid == CAUSE_PORT);
    bus.interrupt_ack = ack;
    db_btns           = btns;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(8'h00, 8'h00, 1'b0, 1'b0, db_btns);
  endtask

  task automatic wr_port(input logic [7:0] pid, input logic [7:0] data);
    step(pid, data, 1'b1, 1'b0, db_btns);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_irq(input string name, input int budget);
    int n = 0;
    while (bus.interrupt !== 1'b1 && n < budget) begin
      idle();
      n++;
    end
    check(name, bus.interrupt, 1'b1);
  endtask

  task automatic count_irq(input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      idle();
      if (bus.interrupt === 1'b1) hits++;
    end
  endtask

  initial begin
    int hits;
    tbl[0]  = '{8'h0A, 8'h02, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{8'h00, 8'h00, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{8'h00, 8'h00, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{8'h00, 8'h00, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{8'h00, 8'h00, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{8'h0C, 8'h00, 1'b0, 1'b0, 4'h1, 1'b0, 1'b1, 8'h02};
    tbl[6]  = '{8'h0C, 8'h00, 1'b0, 1'b0, 4'h1, 1'b0, 1'b1, 8'h02};
    tbl[7]  = '{8'h00, 8'h00, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{8'h00, 8'h00, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{8'h0D, 8'h00, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{8'h00, 8'h00, 1'b0, 1'b0, 4'h3, 1'b1, 1'b0, 8'h00};
    tbl[11] = '{8'h00, 8'h00, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{8'h0C, 8'h00, 1'b0, 1'b0, 4'h7, 1'b0, 1'b1, 8'h02};
    tbl[13] = '{8'h0D, 8'h00, 1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 8'h00};
    tbl[14] = '{8'h00, 8'h00, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 8'h00};
    tbl[15] = '{8'h0D, 8'h00, 1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 8'h00};
    tbl[16] = '{8'h00, 8'h00, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 8'h00};

    chk_en = 1'b0;
    reset_n = 1'b0;
    db_btns = 4'h0;
    bus.port_id = 8'h00; bus.out_port = 8'h00; bus.write_strobe = 1'b0;
    bus.read_strobe = 1'b0; bus.interrupt_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_interrupt", bus.interrupt, 1'b0);
    check("rst_in_port", bus.irq_in_port, 8'h00);
    check("rst_rd_sel", bus.irq_rd_sel, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table: button events, service, EOI re-raise, ack-cycle event, idle EOI
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].pid, tbl[i].data, tbl[i].wr, tbl[i].ack, tbl[i].btns);
      check($sformatf("tbl_irq[%0d]", i), bus.interrupt, tbl[i].exp_irq);
      check($sformatf("tbl_sel[%0d]", i), bus.irq_rd_sel, tbl[i].exp_sel);
      check($sformatf("tbl_rd[%0d]", i), bus.irq_in_port, tbl[i].exp_rd);
    end

    // Reset while interrupt is asserted
    do_reset();
    wr_port(CFG_PORT, 8'h01);
    wr_port(PERIOD_PORT, 8'h03);
    wait_irq("t1_irq_before_reset", 40);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("t1_irq_after_reset", bus.interrupt, 1'b0);
    check("t1_state_after_reset", bus.fsm_state, IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    step(CAUSE_PORT, 8'h00, 1'b0, 1'b0, db_btns);
    check("t1_cause_cleared", bus.irq_in_port, 8'h00);
    count_irq(100, hits);
    check("t1_no_irq_100", hits, 0);

    // Periodic tick, ack, cause read, EOI
    do_reset();
    wr_port(CFG_PORT, 8'h01);
    wr_port(PERIOD_PORT, 8'h03);
    wait_irq("t2_first_tick", 40);
    step(8'h00, 8'h00, 1'b0, 1'b1, db_btns);
    check("t2_irq_drop_on_ack", bus.interrupt, 1'b0);
    step(CAUSE_PORT, 8'h00, 1'b0, 1'b0, db_btns);
    check("t2_cause", bus.irq_in_port, 8'h01);
    wr_port(EOI_PORT, 8'h00);
    check("t2_state_idle", bus.fsm_state, IDLE);
    wait_irq("t2_second_tick", 20);
    step(8'h00, 8'h00, 1'b0, 1'b1, db_btns);
    wr_port(EOI_PORT, 8'h00);

    // Overrun: ack withheld across two tick periods
    do_reset();
    wr_port(CFG_PORT, 8'h07);
    wr_port(PERIOD_PORT, 8'h03);
    wait_irq("t3_first_tick", 40);
    repeat (26) idle();
    check("t3_irq_held", bus.interrupt, 1'b1);
    step(8'h00, 8'h00, 1'b0, 1'b1, db_btns);
    step(CAUSE_PORT, 8'h00, 1'b0, 1'b0, db_btns);
    check("t3_cause_ovr", bus.irq_in_port, 8'h05);
    wr_port(EOI_PORT, 8'h00);

    // Period 0 while running stops the interrupts; EOI in IDLE is ignored
    do_reset();
    wr_port(CFG_PORT, 8'h01);
    wr_port(PERIOD_PORT, 8'h01);
    wait_irq("t6_tick", 20);
    wr_port(PERIOD_PORT, 8'h00);
    step(8'h00, 8'h00, 1'b0, 1'b1, db_btns);
    wr_port(EOI_PORT, 8'h00);
    count_irq(200, hits);
    check("t6_no_irq_200", hits, 0);
    wr_port(EOI_PORT, 8'h00);
    check("t6_eoi_idle_state", bus.fsm_state, IDLE);
    check("t6_eoi_idle_irq", bus.interrupt, 1'b0);

    // Randomized traffic checked against the model every cycle
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] pid, data;
      logic       wr, ack;
      logic [3:0] btns;
      wr   = ($urandom_range(0, 7) == 0);
      data = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0:       pid = CFG_PORT;
        1:       begin pid = PERIOD_PORT; data = 8'($urandom_range(0, 3)); end
        default: pid = EOI_PORT;
      endcase
      if (!wr) pid = ($urandom_range(0, 1) == 0) ? CAUSE_PORT : 8'h00;
      ack  = (bus.interrupt === 1'b1) ? ($urandom_range(0, 3) == 0)
                                       : ($urandom_range(0, 31) == 0);
      btns = db_btns;
      if ($urandom_range(0, 15) == 0) btns[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 499) == 0) do_reset();
      step(pid, data, wr, ack, btns);
    end

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
